// File: rtl/hdc_pkg.sv
// Shared HDC helpers: encoder state encoding, constant clog2 and hypervector rotation.
// Pure package; no timing or flow control of its own.
package hdc_pkg;

    localparam int HV_DIM_DEFAULT = 2048;
    localparam int HV_MAX         = 8192;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } encState_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

    // Rotate right by 'amount' within the low 'width' bits: rho(8'h01) = 8'h80.
    function automatic logic [HV_MAX-1:0] rotateRight(input logic [HV_MAX-1:0] vec,
                                                      input int width, input int amount);
        logic [HV_MAX-1:0] rotated;
        rotated = '0;
        for (int i = 0; i < width; i++) begin
            rotated[i] = vec[(i + amount) % width];
        end
        return rotated;
    endfunction

endpackage

// File: rtl/hv_majority_accumulator.sv
// Per-bit N-gram counters with bitwise majority; Majority_DO registers on the last add of a window.
// Latency 1 cycle from the last Enable_SI; no handshake, the caller gates Enable_SI.
module hv_majority_accumulator
    import hdc_pkg::*;
#(
    parameter int HV_DIM      = HV_DIM_DEFAULT,
    parameter int ACCUM_COUNT = 5
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              Clear_SI,
    input  logic              Enable_SI,
    input  logic              Load_SI,
    input  logic              Last_SI,
    input  logic [HV_DIM-1:0] Ngram_DI,
    output logic [HV_DIM-1:0] Majority_DO
);

    localparam int CNT_W = clog2(ACCUM_COUNT + 1);

    logic [CNT_W-1:0]  cnt     [HV_DIM];
    logic [CNT_W-1:0]  sumNext [HV_DIM];
    logic [HV_DIM-1:0] majNext;

    // Load restarts a window without a separate clear cycle; ties resolve to 0.
    always_comb begin
        majNext = '0;
        for (int b = 0; b < HV_DIM; b++) begin
            sumNext[b] = (Load_SI ? '0 : cnt[b]) + CNT_W'(Ngram_DI[b]);
            majNext[b] = (2 * int'(sumNext[b])) > ACCUM_COUNT;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            for (int b = 0; b < HV_DIM; b++) begin
                cnt[b] <= '0;
            end
            Majority_DO <= '0;
        end else if (Clear_SI) begin
            for (int b = 0; b < HV_DIM; b++) begin
                cnt[b] <= '0;
            end
        end else if (Enable_SI) begin
            for (int b = 0; b < HV_DIM; b++) begin
                cnt[b] <= sumNext[b];
            end
            if (Last_SI) begin
                Majority_DO <= majNext;
            end
        end
    end

endmodule

// File: rtl/temporal_ngram_encoder.sv
// Sliding N-gram binder over the last NGRAM_SIZE-1 inputs, majority-bundled over ACCUM_COUNT N-grams.
// Output valid the cycle after the last N-gram of a window; input stalls (ReadyOut_SO=0) while an output waits.
module temporal_ngram_encoder
    import hdc_pkg::*;
#(
    parameter int HV_DIM      = HV_DIM_DEFAULT,
    parameter int NGRAM_SIZE  = 3,
    parameter int ACCUM_COUNT = 5
) (
    input  logic              Clk_CI,
    input  logic              Rst_RBI,
    input  logic              ValidIn_SI,
    output logic              ReadyOut_SO,
    input  logic [HV_DIM-1:0] HypervectorIn_DI,
    input  logic              Flush_SI,
    output logic              ValidOut_SO,
    input  logic              ReadyIn_SI,
    output logic [HV_DIM-1:0] HypervectorOut_DO,
    output logic              Filled_SO
);

    localparam int        FILL_W      = (NGRAM_SIZE > 2) ? clog2(NGRAM_SIZE) : 1;
    localparam int        WIN_W       = clog2(ACCUM_COUNT + 1);
    localparam encState_t START_STATE = (NGRAM_SIZE == 1) ? ACCUM : FILL;

    encState_t         state, stateNext;
    logic [FILL_W-1:0] fillCnt, fillCntNext;
    logic [WIN_W-1:0]  winCnt, winCntNext;
    logic              accept, accumEn, lastNgram;
    logic [HV_DIM-1:0] ngram;

    assign ReadyOut_SO = (state != OUTPUT);
    assign ValidOut_SO = (state == OUTPUT);
    assign Filled_SO   = (state != FILL);
    assign accept      = ValidIn_SI & ReadyOut_SO;
    assign accumEn     = accept & (state == ACCUM) & ~Flush_SI;
    assign lastNgram   = (winCnt == WIN_W'(ACCUM_COUNT - 1));

    always_comb begin
        stateNext   = state;
        fillCntNext = fillCnt;
        winCntNext  = winCnt;
        if (Flush_SI) begin
            stateNext   = START_STATE;
            fillCntNext = '0;
            winCntNext  = '0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        if (fillCnt == FILL_W'(NGRAM_SIZE - 2)) begin
                            stateNext   = ACCUM;
                            fillCntNext = '0;
                        end else begin
                            fillCntNext = fillCnt + 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        if (lastNgram) begin
                            stateNext  = OUTPUT;
                            winCntNext = '0;
                        end else begin
                            winCntNext = winCnt + 1'b1;
                        end
                    end
                end
                OUTPUT: begin
                    if (ReadyIn_SI) begin
                        stateNext = ACCUM;
                    end
                end
                default: stateNext = START_STATE;
            endcase
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state   <= START_STATE;
            fillCnt <= '0;
            winCnt  <= '0;
        end else begin
            state   <= stateNext;
            fillCnt <= fillCntNext;
            winCnt  <= winCntNext;
        end
    end

    if (NGRAM_SIZE > 1) begin : gHistory
        logic [HV_DIM-1:0] hist [NGRAM_SIZE-1];

        // History survives window boundaries so N-grams slide across outputs.
        always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
            if (!Rst_RBI) begin
                for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
                    hist[k] <= '0;
                end
            end else if (Flush_SI) begin
                for (int k = 0; k < NGRAM_SIZE - 1; k++) begin
                    hist[k] <= '0;
                end
            end else if (accept) begin
                hist[0] <= HypervectorIn_DI;
                for (int k = 1; k < NGRAM_SIZE - 1; k++) begin
                    hist[k] <= hist[k-1];
                end
            end
        end

        always_comb begin
            ngram = HypervectorIn_DI;
            for (int k = 1; k < NGRAM_SIZE; k++) begin
                ngram = ngram ^ HV_DIM'(rotateRight(HV_MAX'(hist[k-1]), HV_DIM, k));
            end
        end
    end else begin : gNoHistory
        assign ngram = HypervectorIn_DI;
    end

    hv_majority_accumulator #(
        .HV_DIM      (HV_DIM),
        .ACCUM_COUNT (ACCUM_COUNT)
    ) i_majorityAcc (
        .Clk_CI      (Clk_CI),
        .Rst_RBI     (Rst_RBI),
        .Clear_SI    (Flush_SI),
        .Enable_SI   (accumEn),
        .Load_SI     (winCnt == '0),
        .Last_SI     (lastNgram),
        .Ngram_DI    (ngram),
        .Majority_DO (HypervectorOut_DO)
    );

endmodule

// File: tb/tb_temporal_ngram_encoder.sv
// Five 8-bit encoder configurations driven side by side; directed cases then random traffic,
// every cycle compared against a queue/arithmetic reference of the N-gram/majority rules.
module tb_temporal_ngram_encoder;

    localparam int NI         = 5;
    localparam int NG [NI]    = '{2, 1, 1, 3, 3};
    localparam int AC [NI]    = '{1, 3, 2, 2, 5};

    logic                 clk;
    logic                 rstN;
    logic [NI-1:0]        vin, rdyOut, flush, vout, rdyIn, filled;
    logic [NI-1:0][7:0]   din, dout;

    int vecCnt = 0;
    int errCnt = 0;

    int         mFill [NI];
    int         mWin  [NI];
    bit         mPend [NI];
    logic [7:0] mOut  [NI];
    logic [7:0] mHist [NI][8];
    int         mSum  [NI][8];

    for (genvar g = 0; g < NI; g++) begin : gDut
        temporal_ngram_encoder #(
            .HV_DIM      (8),
            .NGRAM_SIZE  (NG[g]),
            .ACCUM_COUNT (AC[g])
        ) u_dut (
            .Clk_CI            (clk),
            .Rst_RBI           (rstN),
            .ValidIn_SI        (vin[g]),
            .ReadyOut_SO       (rdyOut[g]),
            .HypervectorIn_DI  (din[g]),
            .Flush_SI          (flush[g]),
            .ValidOut_SO       (vout[g]),
            .ReadyIn_SI        (rdyIn[g]),
            .HypervectorOut_DO (dout[g]),
            .Filled_SO         (filled[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecCnt++;
        if (obs !== exp) begin
            errCnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [7:0] rotr8(input logic [7:0] x, input int k);
        int v;
        v = x;
        return 8'(((v >> k) | (v << (8 - k))) & 255);
    endfunction

    task automatic modelClear(input int i);
        mFill[i] = 0;
        mWin[i]  = 0;
        mPend[i] = 0;
        for (int k = 0; k < 8; k++) begin
            mHist[i][k] = 8'h00;
            mSum[i][k]  = 0;
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < NI; i++) begin
            modelClear(i);
            mOut[i] = 8'h00;
        end
    endtask

    task automatic modelStep(input int i);
        logic [7:0] b;
        if (flush[i]) begin
            modelClear(i);
        end else if (mPend[i]) begin
            if (rdyIn[i]) mPend[i] = 0;
        end else if (vin[i]) begin
            if (mFill[i] == NG[i] - 1) begin
                b = din[i];
                for (int k = 1; k < NG[i]; k++) b = b ^ rotr8(mHist[i][k-1], k);
                for (int j = 0; j < 8; j++) mSum[i][j] = (mWin[i] == 0 ? 0 : mSum[i][j]) + int'(b[j]);
                mWin[i]++;
                if (mWin[i] == AC[i]) begin
                    for (int j = 0; j < 8; j++) mOut[i][j] = (2 * mSum[i][j] > AC[i]);
                    mWin[i]  = 0;
                    mPend[i] = 1;
                end
            end else begin
                mFill[i]++;
            end
            for (int k = 7; k > 0; k--) mHist[i][k] = mHist[i][k-1];
            mHist[i][0] = din[i];
        end
    endtask

    task automatic checkAll();
        for (int i = 0; i < NI; i++) begin
            checkVal($sformatf("ctl%0d", i), 32'({vout[i], rdyOut[i], filled[i]}),
                     32'({mPend[i], !mPend[i], mFill[i] == NG[i] - 1}));
            checkVal($sformatf("hv%0d", i), 32'(dout[i]), 32'(mOut[i]));
        end
    endtask

    // Inputs are set after a posedge; outputs checked on the negedge, model advanced with the edge.
    task automatic stepCycle();
        @(negedge clk);
        checkAll();
        for (int i = 0; i < NI; i++) modelStep(i);
        @(posedge clk);
        #1;
    endtask

    task automatic idleAll();
        vin   = '0;
        flush = '0;
        rdyIn = '1;
        din   = '0;
    endtask

    task automatic randomize_inputs();
        for (int i = 0; i < NI; i++) begin
            vin[i]   = ($urandom_range(3) != 0);
            din[i]   = 8'($urandom);
            rdyIn[i] = ($urandom_range(2) != 0);
            flush[i] = ($urandom_range(40) == 0);
        end
    endtask

    initial begin
        rstN = 1'b0;
        idleAll();
        modelReset();
        #12;
        checkAll();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        // Binding and sliding history: N=2, ACCUM=1
        vin[0] = 1'b1; din[0] = 8'h01;
        stepCycle();
        checkVal("bindFilled", 32'(filled[0]), 32'd1);
        stepCycle();
        checkVal("bindValid", 32'(vout[0]), 32'd1);
        checkVal("bindHv", 32'(dout[0]), 32'h81);
        din[0] = 8'h80;
        stepCycle();
        checkVal("bindRelease", 32'(vout[0]), 32'd0);
        stepCycle();
        checkVal("slideValid", 32'(vout[0]), 32'd1);
        checkVal("slideHv", 32'(dout[0]), 32'h00);
        vin[0] = 1'b0;
        stepCycle();

        // Majority: N=1, ACCUM=3
        vin[1] = 1'b1;
        din[1] = 8'hF0; stepCycle();
        din[1] = 8'hCC; stepCycle();
        din[1] = 8'hAA; stepCycle();
        checkVal("majValid", 32'(vout[1]), 32'd1);
        checkVal("majHv", 32'(dout[1]), 32'hE8);
        vin[1] = 1'b0;
        stepCycle();

        // Tie resolves to 0: N=1, ACCUM=2
        vin[2] = 1'b1;
        din[2] = 8'hFF; stepCycle();
        din[2] = 8'h0F; stepCycle();
        checkVal("tieHv", 32'(dout[2]), 32'h0F);
        vin[2] = 1'b0;
        stepCycle();

        // Backpressure on instance 0 (history holds 8'h80)
        vin[0] = 1'b1; din[0] = 8'h3C; rdyIn[0] = 1'b0;
        stepCycle();
        checkVal("bpHv", 32'(dout[0]), 32'h7C);
        for (int n = 0; n < 5; n++) begin
            vin[0] = n[0];
            din[0] = 8'($urandom);
            stepCycle();
            checkVal("bpValid", 32'(vout[0]), 32'd1);
            checkVal("bpReady", 32'(rdyOut[0]), 32'd0);
            checkVal("bpHold", 32'(dout[0]), 32'h7C);
        end
        vin[0] = 1'b0; rdyIn[0] = 1'b1;
        stepCycle();
        checkVal("bpDoneValid", 32'(vout[0]), 32'd0);
        checkVal("bpDoneReady", 32'(rdyOut[0]), 32'd1);
        vin[0] = 1'b1; din[0] = 8'h01;
        stepCycle();
        checkVal("bpHistHv", 32'(dout[0]), 32'h1F);
        vin[0] = 1'b0;
        stepCycle();

        // Flush: N=3, ACCUM=2
        vin[3] = 1'b1;
        din[3] = 8'h11; stepCycle();
        din[3] = 8'h22; stepCycle();
        checkVal("flFilled", 32'(filled[3]), 32'd1);
        flush[3] = 1'b1; din[3] = 8'h33;
        stepCycle();
        flush[3] = 1'b0;
        checkVal("flCleared", 32'(filled[3]), 32'd0);
        din[3] = 8'h44; stepCycle();
        checkVal("flRefill1", 32'(filled[3]), 32'd0);
        din[3] = 8'h55; stepCycle();
        checkVal("flRefill2", 32'(filled[3]), 32'd1);
        din[3] = 8'h66; stepCycle();
        din[3] = 8'h77; rdyIn[3] = 1'b0; stepCycle();
        checkVal("flOutValid", 32'(vout[3]), 32'd1);
        checkVal("flOutHv", 32'(dout[3]), 32'h11);
        vin[3] = 1'b0; flush[3] = 1'b1;
        stepCycle();
        checkVal("flDropValid", 32'(vout[3]), 32'd0);
        checkVal("flKeepHv", 32'(dout[3]), 32'h11);
        idleAll();
        stepCycle();

        // Random traffic, then asynchronous reset mid-stream
        for (int n = 0; n < 300; n++) begin
            randomize_inputs();
            stepCycle();
        end
        #3;
        rstN = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            checkVal($sformatf("rstValid%0d", i), 32'(vout[i]), 32'd0);
            checkVal($sformatf("rstReady%0d", i), 32'(rdyOut[i]), 32'd1);
            checkVal($sformatf("rstFilled%0d", i), 32'(filled[i]), 32'(NG[i] == 1));
            checkVal($sformatf("rstHv%0d", i), 32'(dout[i]), 32'h00);
        end
        idleAll();
        modelReset();
        @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < 1500; n++) begin
            randomize_inputs();
            stepCycle();
        end
        idleAll();
        stepCycle();

        $display("== %0d vectors applied, %0d miscompares ==", vecCnt, errCnt);
        $finish;
    end

endmodule

// File: doc/temporal_ngram_encoder.md
Name: temporal_ngram_encoder

Overview:
Parametrised successor to the fixed 2-gram temporal encoder. It keeps a history of the last NGRAM_SIZE-1 accepted hypervectors and binds each new input with that history into an N-gram, as a XOR of successively rotated members. It sums ACCUM_COUNT consecutive N-grams per bit and emits their bitwise majority over a valid/ready handshake. It sits between the spatial encoder and associative memory.

Parameters:
HV_DIM, 2048, hypervector width in bits (>=2).
NGRAM_SIZE, 3, N-gram length (1..8).
ACCUM_COUNT, 5, N-grams per output window (>=1).

Ports:
Clk_CI  in  1  clock.
Rst_RBI  in  1  asynchronous active-low reset.
ValidIn_SI  in  1  input hypervector valid.
ReadyOut_SO  out  1  block can accept input.
HypervectorIn_DI  in  HV_DIM  input hypervector.
Flush_SI  in  1  synchronous clear of history and window.
ValidOut_SO  out  1  output hypervector valid.
ReadyIn_SI  in  1  downstream ready.
HypervectorOut_DO  out  HV_DIM  majority hypervector (registered).
Filled_SO  out  1  history full; every accept now yields an N-gram.

Behaviour:
- Reset (Rst_RBI=0, async): ValidOut_SO=0, HypervectorOut_DO=0, Filled_SO=(NGRAM_SIZE==1), all history/counters=0, state=FILL (or ACCUM if NGRAM_SIZE==1). ReadyOut_SO=1.
- Accept = ValidIn_SI & ReadyOut_SO. ReadyOut_SO=1 in FILL and ACCUM, 0 in OUTPUT (no skid buffer).
- rho(x) = rotate right by one, numeric LSB-0: rho(8'h01)=8'h80. rho^k = k-fold rotation.
- History h[0..N-2]: h[0] is the most recent accepted input. On accept: h[0]<=In, h[k]<=h[k-1].
- Bound N-gram (combinational, from current In and old history): B = In ^ rho(h[0]) ^ rho^2(h[1]) ^ ... ^ rho^(N-1)(h[N-2]).
- FILL: count accepts. The (N-1)-th accept moves to ACCUM and sets Filled_SO. No accumulation happens in FILL.
- ACCUM: each accept adds B to the per-bit counters (width clog2(ACCUM_COUNT+1)) and increments WinCnt.
  - The first N-gram of a window loads the counters (no separate clear cycle).
  - The accept that brings WinCnt to ACCUM_COUNT goes to OUTPUT.
  - On that same edge, HypervectorOut_DO[b] <= ((cnt[b]+B[b])*2 > ACCUM_COUNT) and WinCnt <= 0. Ties (even ACCUM_COUNT) resolve to 0.
- OUTPUT: ValidOut_SO=1. HypervectorOut_DO is held stable until ReadyIn_SI=1. That edge returns to ACCUM; history is kept (sliding N-gram across windows). ValidIn_SI is ignored here.
- Latency: ValidOut_SO rises on the cycle after the ACCUM_COUNT-th N-gram accept. Sustained throughput is 1 output per ACCUM_COUNT+1 cycles with ReadyIn_SI=1.
- Flush_SI=1 (any state): next edge clears history, counters, WinCnt and Filled_SO, sets ValidOut_SO=0, and enters FILL.
  - Flush has priority over a same-cycle accept, and that input is dropped.
  - A pending output is discarded.
  - HypervectorOut_DO keeps its last value.
- Counter wrap: WinCnt never exceeds ACCUM_COUNT. Per-bit counters saturate by construction.
- Async reset mid-window or mid-OUTPUT: immediate return to reset values. No partial output survives.

Decomposition:
- Shared package hdc_pkg: clog2 function, rho/rotate function, HV_DIM default, and the state encoding (FILL, ACCUM, OUTPUT).
- Sub-module hv_majority_accumulator (parameters HV_DIM, ACCUM_COUNT) contains the per-bit counters, load/add enable, and majority threshold.
- The encoder top contains history, binder, FSM and handshake.

Test Plan:
- Reset: drive Rst_RBI=0 mid-stream -> ValidOut_SO=0, HypervectorOut_DO=0, ReadyOut_SO=1, Filled_SO=0 immediately, without waiting for a clock edge.
- Binding, HV_DIM=8, N=2, ACCUM=1: accept 8'h01 then 8'h01 -> Filled_SO=1 after the first accept; ValidOut_SO=1 one cycle after the second, with 8'h81. Then accept 8'h80 -> 8'h00 (sliding history).
- Majority, N=1, ACCUM=3: accept 8'hF0, 8'hCC, 8'hAA -> 8'hE8.
- Tie, N=1, ACCUM=2: accept 8'hFF, 8'h0F -> 8'h0F; bits with count 1 give 0.
- Backpressure: hold ReadyIn_SI=0 for 5 cycles in OUTPUT while toggling ValidIn_SI -> output stable, ReadyOut_SO=0, no history change. Raise ReadyIn_SI -> next cycle ValidOut_SO=0, ReadyOut_SO=1.
- Flush, N=3, ACCUM=2: flush in the same cycle as the first ACCUM accept -> input dropped, Filled_SO=0, and two further accepts are needed before the next N-gram counts. Flush in OUTPUT -> ValidOut_SO drops next cycle.
